// File: rtl/wb_pkg.sv
// wb_pkg: shared defaults and entry layout for the write-back buffer.
// Forwarding lookup is optional, enabled by defining WB_FORWARD_EN.
package wb_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 5;
    localparam int WB_DEPTH  = 4;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0] wd;
    } entry_t;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: circular storage for pending register writes.
// Exposes the whole array and read pointer for forwarding lookups.
module wb_fifo
    import wb_pkg::*;
#(
    parameter  int DATA_W = WB_DATA_W,
    parameter  int ADDR_W = WB_ADDR_W,
    parameter  int DEPTH  = WB_DEPTH,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic [ADDR_W-1:0]            i_rd,
    input  logic [DATA_W-1:0]            i_wd,
    output logic [ADDR_W-1:0]            o_head_rd,
    output logic [DATA_W-1:0]            o_head_wd,
    output logic [CNT_W-1:0]             o_count,
    output logic [PTR_W-1:0]             o_rd_ptr,
    output logic [DEPTH-1:0][ADDR_W-1:0] o_mem_rd,
    output logic [DEPTH-1:0][DATA_W-1:0] o_mem_wd
);

    logic [DEPTH-1:0][ADDR_W-1:0] r_mem_rd;
    logic [DEPTH-1:0][DATA_W-1:0] r_mem_wd;
    logic [PTR_W-1:0]             r_wr_ptr;
    logic [PTR_W-1:0]             r_rd_ptr;
    logic [CNT_W-1:0]             r_count;

    // Entry payload; validity is tracked by count, so no reset needed.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem_rd[r_wr_ptr] <= i_rd;
            r_mem_wd[r_wr_ptr] <= i_wd;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!i_push && i_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    assign o_head_rd = r_mem_rd[r_rd_ptr];
    assign o_head_wd = r_mem_wd[r_rd_ptr];
    assign o_count   = r_count;
    assign o_rd_ptr  = r_rd_ptr;
    assign o_mem_rd  = r_mem_rd;
    assign o_mem_wd  = r_mem_wd;

endmodule

// File: rtl/wb_write_buffer.sv
// wb_write_buffer: decouples write-back results from the register file port.
// Define WB_FORWARD_EN to compile in pending-value forwarding for rs/rt.
module wb_write_buffer
    import wb_pkg::*;
#(
    parameter  int DATA_W = WB_DATA_W,
    parameter  int ADDR_W = WB_ADDR_W,
    parameter  int DEPTH  = WB_DEPTH,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [DATA_W-1:0] in_wd,
    input  logic              drain_en,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] rd,
    output logic [DATA_W-1:0] WD,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    output logic              fwd1_hit,
    output logic              fwd2_hit,
    output logic [DATA_W-1:0] fwd1_data,
    output logic [DATA_W-1:0] fwd2_data,
    output logic [CNT_W-1:0]  count
);

    logic                         w_accept;
    logic                         w_push;
    logic                         w_nonempty;
    logic [ADDR_W-1:0]            w_head_rd;
    logic [DATA_W-1:0]            w_head_wd;
    logic [CNT_W-1:0]             w_count;
    logic [PTR_W-1:0]             w_rd_ptr;
    logic [DEPTH-1:0][ADDR_W-1:0] w_mem_rd;
    logic [DEPTH-1:0][DATA_W-1:0] w_mem_wd;

    // Writes to r0 are handshaken but dropped: r0 is hardwired.
    assign in_ready   = (w_count < CNT_W'(DEPTH));
    assign w_accept   = in_valid & in_ready;
    assign w_push     = w_accept & (in_rd != '0);
    assign w_nonempty = (w_count != '0);
    assign RegWrite   = w_nonempty & drain_en;
    assign rd         = w_nonempty ? w_head_rd : '0;
    assign WD         = w_nonempty ? w_head_wd : '0;
    assign count      = w_count;

    wb_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_push    (w_push),
        .i_pop     (RegWrite),
        .i_rd      (in_rd),
        .i_wd      (in_wd),
        .o_head_rd (w_head_rd),
        .o_head_wd (w_head_wd),
        .o_count   (w_count),
        .o_rd_ptr  (w_rd_ptr),
        .o_mem_rd  (w_mem_rd),
        .o_mem_wd  (w_mem_wd)
    );

`ifdef WB_FORWARD_EN

    // Scan oldest to youngest so the last match (youngest) wins.
    function automatic logic [DATA_W:0] f_lookup(
        input logic [ADDR_W-1:0]            key,
        input logic [CNT_W-1:0]             cnt,
        input logic [PTR_W-1:0]             base,
        input logic [DEPTH-1:0][ADDR_W-1:0] mrd,
        input logic [DEPTH-1:0][DATA_W-1:0] mwd
    );
        logic [PTR_W-1:0] idx;
        logic [DATA_W:0]  res;
        res = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = base + PTR_W'(i);
            if (key != '0 && CNT_W'(i) < cnt && mrd[idx] == key) begin
                res = {1'b1, mwd[idx]};
            end
        end
        return res;
    endfunction

    // Zero-latency lookup of pending values for both read ports.
    always_comb begin
        {fwd1_hit, fwd1_data} = f_lookup(rs, w_count, w_rd_ptr,
                                         w_mem_rd, w_mem_wd);
        {fwd2_hit, fwd2_data} = f_lookup(rt, w_count, w_rd_ptr,
                                         w_mem_rd, w_mem_wd);
    end

`else

    logic w_unused;
    assign w_unused  = ^{rs, rt, w_rd_ptr, w_mem_rd, w_mem_wd};
    assign fwd1_hit  = 1'b0;
    assign fwd2_hit  = 1'b0;
    assign fwd1_data = '0;
    assign fwd2_data = '0;

`endif

endmodule

// File: tb/tb_wb_write_buffer.sv
// tb_wb_write_buffer: directed table plus random traffic against a queue model.
// Forwarding expectations follow WB_FORWARD_EN.
module tb_wb_write_buffer;
    import wb_pkg::*;

    localparam int DEPTH = WB_DEPTH;
`ifdef WB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic [31:0] in_wd;
    logic        drain_en;
    logic        RegWrite;
    logic [4:0]  rd;
    logic [31:0] WD;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        fwd1_hit;
    logic        fwd2_hit;
    logic [31:0] fwd1_data;
    logic [31:0] fwd2_data;
    logic [2:0]  count;

    int n_chk = 0;
    int n_err = 0;

    entry_t q[$];

    typedef struct {
        logic        v;
        logic [4:0]  ird;
        logic [31:0] iwd;
        logic        dr;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [2:0]  cnt;
        logic        rdy;
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic        f1h;
        logic [31:0] f1d;
        logic        f2h;
        logic [31:0] f2d;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    wb_write_buffer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rd     (in_rd),
        .in_wd     (in_wd),
        .drain_en  (drain_en),
        .RegWrite  (RegWrite),
        .rd        (rd),
        .WD        (WD),
        .rs        (rs),
        .rt        (rt),
        .fwd1_hit  (fwd1_hit),
        .fwd2_hit  (fwd2_hit),
        .fwd1_data (fwd1_data),
        .fwd2_data (fwd2_data),
        .count     (count)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic v, input logic [4:0] ird, input logic [31:0] iwd,
        input logic dr, input logic [4:0] r1, input logic [4:0] r2,
        input logic [2:0] cnt, input logic rdy, input logic rw,
        input logic [4:0] erd, input logic [31:0] ewd,
        input logic f1h, input logic [31:0] f1d,
        input logic f2h, input logic [31:0] f2d);
        vec_t t;
        t.v = v; t.ird = ird; t.iwd = iwd; t.dr = dr; t.rs = r1; t.rt = r2;
        t.cnt = cnt; t.rdy = rdy; t.rw = rw; t.rd = erd; t.wd = ewd;
        t.f1h = f1h & FWD; t.f1d = FWD ? f1d : 32'h0;
        t.f2h = f2h & FWD; t.f2d = FWD ? f2d : 32'h0;
        return t;
    endfunction

    task automatic drive(input logic v, input logic [4:0] ird,
                         input logic [31:0] iwd, input logic dr,
                         input logic [4:0] r1, input logic [4:0] r2);
        in_valid = v; in_rd = ird; in_wd = iwd;
        drain_en = dr; rs = r1; rt = r2;
    endtask

    // Youngest pending write to a nonzero register is forwarded.
    task automatic exp_fwd(input logic [4:0] key, output logic h,
                           output logic [31:0] d);
        h = 1'b0;
        d = 32'h0;
        if (FWD && key != 5'd0) begin
            foreach (q[i]) begin
                if (q[i].rd == key) begin
                    h = 1'b1;
                    d = q[i].wd;
                end
            end
        end
    endtask

    task automatic check_model(input string tag);
        logic        h1, h2;
        logic [31:0] d1, d2;
        logic [4:0]  erd;
        logic [31:0] ewd;
        exp_fwd(rs, h1, d1);
        exp_fwd(rt, h2, d2);
        erd = 5'd0;
        ewd = 32'h0;
        if (q.size() > 0) begin
            erd = q[0].rd;
            ewd = q[0].wd;
        end
        chk({tag, ".count"}, count, q.size());
        chk({tag, ".ready"}, in_ready, q.size() < DEPTH);
        chk({tag, ".regwrite"}, RegWrite, q.size() > 0 && drain_en);
        chk({tag, ".rd"}, rd, erd);
        chk({tag, ".wd"}, WD, ewd);
        chk({tag, ".f1h"}, fwd1_hit, h1);
        chk({tag, ".f1d"}, fwd1_data, d1);
        chk({tag, ".f2h"}, fwd2_hit, h2);
        chk({tag, ".f2d"}, fwd2_data, d2);
    endtask

    // Effect of the coming edge on the abstract queue.
    task automatic model_edge();
        bit pop;
        bit acc;
        entry_t e;
        pop = q.size() > 0 && drain_en;
        acc = in_valid && q.size() < DEPTH;
        if (pop) void'(q.pop_front());
        if (acc && in_rd != 5'd0) begin
            e.rd = in_rd;
            e.wd = in_wd;
            q.push_back(e);
        end
    endtask

    task automatic cycle(input string tag);
        #1;
        check_model(tag);
        model_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0);
        #2;
        check_model("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);

        tbl.push_back(mk(1, 9, 10, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 10, 20, 1, 0, 0, 1, 1, 1, 9, 10, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 1, 1, 10, 20, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 'hFFFF, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 'h11, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 2, 'h22, 0, 0, 0, 1, 1, 0, 1, 'h11, 0, 0, 0, 0));
        tbl.push_back(mk(1, 3, 'h33, 0, 0, 0, 2, 1, 0, 1, 'h11, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4, 'h44, 0, 0, 0, 3, 1, 0, 1, 'h11, 0, 0, 0, 0));
        tbl.push_back(mk(1, 5, 'h55, 0, 0, 0, 4, 0, 0, 1, 'h11, 0, 0, 0, 0));
        tbl.push_back(mk(1, 5, 'h55, 1, 0, 0, 4, 0, 1, 1, 'h11, 0, 0, 0, 0));
        tbl.push_back(mk(1, 5, 'h55, 1, 0, 0, 3, 1, 1, 2, 'h22, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 3, 1, 1, 3, 'h33, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 2, 1, 1, 4, 'h44, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 1, 1, 5, 'h55, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 9, 1, 0, 9, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 9, 2, 0, 9, 0, 1, 1, 0, 9, 1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 9, 0, 2, 1, 0, 9, 1, 1, 2, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 9, 2, 1, 0, 9, 1, 0, 0, 1, 2));
        tbl.push_back(mk(0, 0, 0, 1, 9, 9, 2, 1, 1, 9, 1, 1, 2, 1, 2));
        tbl.push_back(mk(0, 0, 0, 1, 9, 0, 1, 1, 1, 9, 2, 1, 2, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 9, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            string t;
            t = $sformatf("vec%0d", i);
            drive(tbl[i].v, tbl[i].ird, tbl[i].iwd,
                  tbl[i].dr, tbl[i].rs, tbl[i].rt);
            #1;
            chk({t, ".count"}, count, tbl[i].cnt);
            chk({t, ".ready"}, in_ready, tbl[i].rdy);
            chk({t, ".regwrite"}, RegWrite, tbl[i].rw);
            chk({t, ".rd"}, rd, tbl[i].rd);
            chk({t, ".wd"}, WD, tbl[i].wd);
            chk({t, ".f1h"}, fwd1_hit, tbl[i].f1h);
            chk({t, ".f1d"}, fwd1_data, tbl[i].f1d);
            chk({t, ".f2h"}, fwd2_hit, tbl[i].f2h);
            chk({t, ".f2d"}, fwd2_data, tbl[i].f2d);
            model_edge();
            @(posedge clk);
            #1;
        end

        for (int i = 0; i < 3 * DEPTH + 2; i++) begin
            logic [4:0] r;
            r = 5'($urandom_range(31, 1));
            if (i < 3 * DEPTH) drive(1'b1, r, $urandom, 1'b1, r, 5'd0);
            else drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0);
            cycle("stream");
        end

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(9, 0) < 7, 5'($urandom_range(7, 0)),
                  $urandom, $urandom_range(1, 0) == 1,
                  5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)));
            cycle("rand");
        end

        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0);
        for (int i = 0; i < DEPTH + 1; i++) cycle("flush");

        drive(1'b1, 5'd3, 32'hA3, 1'b0, 5'd3, 5'd5);
        cycle("fill0");
        drive(1'b1, 5'd4, 32'hA4, 1'b0, 5'd3, 5'd5);
        cycle("fill1");
        drive(1'b1, 5'd5, 32'hA5, 1'b0, 5'd3, 5'd5);
        cycle("fill2");
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd5);
        #1;
        check_model("pre_rst");
        #1;
        rst_n = 1'b0;
        q.delete();
        #1;
        check_model("async_rst");
        @(posedge clk);
        #1;
        check_model("held_rst");
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cycle("post_rst");
        drive(1'b1, 5'd7, 32'h77, 1'b1, 5'd7, 5'd0);
        cycle("first_acc");
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd0);
        cycle("first_out");
        cycle("idle");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
